// File: rtl/branch_history_table.sv
// Gshare branch history table: 2-bit saturating counters indexed by PC ^ GHR,
// with a speculatively shifted global history register that is repaired on mispredict.
module branch_history_table #(
   parameter int INDEX_BITS = 3,
   parameter int HIST_BITS  = 3   // 2 <= HIST_BITS <= INDEX_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [15:0]          fetch_pc,
   input  logic                 fetch_is_branch,
   output logic                 pred_taken,
   output logic [HIST_BITS-1:0] pred_ghr,
   input  logic                 load_bht,
   input  logic                 clear_bht,
   input  logic [15:0]          update_pc,
   input  logic [HIST_BITS-1:0] update_ghr,
   input  logic                 update_taken,
   input  logic                 update_mispredict
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   localparam logic [1:0] CNT_SNT = 2'b00;
   localparam logic [1:0] CNT_WNT = 2'b01;
   localparam logic [1:0] CNT_WT  = 2'b10;
   localparam logic [1:0] CNT_ST  = 2'b11;

   logic [1:0]            cnt_q [ENTRIES];
   logic [1:0]            cnt_old;
   logic [1:0]            cnt_d;
   logic                  cnt_we;
   logic [HIST_BITS-1:0]  ghr_q;
   logic [HIST_BITS-1:0]  ghr_d;
   logic [INDEX_BITS-1:0] fetch_hist;
   logic [INDEX_BITS-1:0] update_hist;
   logic [INDEX_BITS-1:0] fetch_idx;
   logic [INDEX_BITS-1:0] update_idx;
   logic                  unused_pc_bits;

   // History is zero-extended into the index width before hashing with the PC.
   always_comb begin
      fetch_hist                   = '0;
      fetch_hist[HIST_BITS-1:0]    = ghr_q;
      update_hist                  = '0;
      update_hist[HIST_BITS-1:0]   = update_ghr;
   end

   assign fetch_idx  = fetch_pc[INDEX_BITS:1]  ^ fetch_hist;
   assign update_idx = update_pc[INDEX_BITS:1] ^ update_hist;

   assign unused_pc_bits = ^{fetch_pc[15:INDEX_BITS+1], fetch_pc[0],
                             update_pc[15:INDEX_BITS+1], update_pc[0]};

   // Lookup reads registered state only, so a same-cycle write is not bypassed.
   assign pred_taken = cnt_q[fetch_idx][1];
   assign pred_ghr   = ghr_q;

   // load_bht/clear_bht are single-cycle strobes with no handshake: each cycle
   // either is high, the selected entry is written on that rising edge.
   always_comb begin
      cnt_old = cnt_q[update_idx];
      cnt_we  = load_bht | clear_bht;
      cnt_d   = cnt_old;
      if (load_bht && clear_bht) begin
         cnt_d = update_taken ? CNT_WT : CNT_WNT;
      end else if (clear_bht) begin
         cnt_d = CNT_WNT;
      end else if (load_bht) begin
         if (update_taken) begin
            cnt_d = (cnt_old == CNT_ST) ? CNT_ST : cnt_old + 2'b01;
         end else begin
            cnt_d = (cnt_old == CNT_SNT) ? CNT_SNT : cnt_old - 2'b01;
         end
      end
   end

   // Repair takes priority over the speculative fetch shift.
   always_comb begin
      ghr_d = ghr_q;
      if (load_bht && update_mispredict) begin
         ghr_d = {update_ghr[HIST_BITS-2:0], update_taken};
      end else if (fetch_is_branch) begin
         ghr_d = {ghr_q[HIST_BITS-2:0], pred_taken};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            cnt_q[i] <= CNT_WNT;
         end
         ghr_q <= '0;
      end else begin
         if (cnt_we) begin
            cnt_q[update_idx] <= cnt_d;
         end
         ghr_q <= ghr_d;
      end
   end

endmodule
